lsu_spill_bus_sequencer: RTL and testbench

- Sits directly downstream of the LSU alignment/spill stage, on the uncached (bus) path.
- Consumes the double-width (2*LLEN) write data and byte mask the alignment stage produces.
- Issues one or two LLEN-wide aligned bus beats with a valid/ready handshake, then returns merged 2*LLEN read data to the alignment stage for shifting.
- Stalls the memory stage until every required beat has completed.

---
 rtl/lsu_spill_bus_sequencer_pkg.sv | 18 +
 rtl/lsu_spill_bus_sequencer_beat_mux.sv | 27 ++
 rtl/lsu_spill_bus_sequencer.sv | 130 +++++++++++++
 tb/tb_lsu_spill_bus_sequencer.sv | 294 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/lsu_spill_bus_sequencer_pkg.sv
// Shared LSU definitions for the uncached spill bus sequencer.
package lsu_spill_bus_sequencer_pkg;

  localparam int LSU_XLEN  = 64;
  localparam int LSU_LLEN  = 64;
  localparam int LLENBYTES = LSU_LLEN / 8;

  localparam logic [1:0] MEMRW_READ  = 2'b10;
  localparam logic [1:0] MEMRW_WRITE = 2'b01;

  typedef logic [1:0] seq_state_t;

  localparam seq_state_t ST_IDLE  = 2'd0;
  localparam seq_state_t ST_BEAT0 = 2'd1;
  localparam seq_state_t ST_BEAT1 = 2'd2;
  localparam seq_state_t ST_DONE  = 2'd3;

endpackage

// File: rtl/lsu_spill_bus_sequencer_beat_mux.sv
// Selects the LLEN-wide half of the captured spill data/mask for the beat on the bus.
module lsu_beat_mux
  import lsu_spill_bus_sequencer_pkg::*;
#(
  parameter int LLEN = 64
) (
  input  logic [1:0]          state,
  input  logic [2*LLEN-1:0]   data_spill,
  input  logic [2*LLEN/8-1:0] mask_spill,
  output logic [LLEN-1:0]     beat_data,
  output logic [LLEN/8-1:0]   beat_mask
);

  localparam int BB = LLEN / 8;

  // beat 1 carries the high half; every other state presents the low half
  always_comb begin
    if (state == ST_BEAT1) begin
      beat_data = data_spill[2*LLEN-1:LLEN];
      beat_mask = mask_spill[2*BB-1:BB];
    end else begin
      beat_data = data_spill[LLEN-1:0];
      beat_mask = mask_spill[BB-1:0];
    end
  end

endmodule

// File: rtl/lsu_spill_bus_sequencer.sv
// Uncached bus sequencer behind the LSU spill stage: issues one or two aligned
// LLEN beats for a 2*LLEN spill access and merges the read beats.
//
// state    | meaning
// ---------+-----------------------------------------------------------
// IDLE     | no access in flight; accepts a new read/write request
// BEAT0    | low-half beat on the bus, waiting for BusReady
// BEAT1    | high-half beat on the bus, waiting for BusReady
// DONE     | all beats complete; waits for the pipeline to unstall
module lsu_spill_bus_sequencer
  import lsu_spill_bus_sequencer_pkg::*;
#(
  parameter int XLEN = LSU_XLEN,
  parameter int LLEN = LSU_LLEN
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    StallM,
  input  logic                    FlushM,
  input  logic                    ReqM,
  input  logic [1:0]              MemRWM,
  input  logic [XLEN-1:0]         IEUAdrM,
  input  logic [2*LLEN-1:0]       LSUWriteDataSpillM,
  input  logic [2*LLEN/8-1:0]     ByteMaskSpillM,
  output logic [XLEN-1:0]         BusAdr,
  output logic                    BusRead,
  output logic                    BusWrite,
  output logic [LLEN/8-1:0]       BusByteMask,
  output logic [LLEN-1:0]         BusWriteData,
  input  logic                    BusReady,
  input  logic [LLEN-1:0]         BusReadData,
  output logic [2*LLEN-1:0]       ReadDataSpillM,
  output logic                    SeqStallM
);

  localparam int BB = LLEN / 8;

  seq_state_t            state, state_next;
  logic [1:0]            rw_q;
  logic [XLEN-1:0]       base_q;
  logic [2*LLEN-1:0]     wdata_q;
  logic [2*BB-1:0]       mask_q;
  logic                  need1_q;
  logic                  flush_pend;
  logic [2*LLEN-1:0]     rdata_q;

  logic rw_valid, start, need1, in_beat, flush_eff, last_beat;

  assign rw_valid  = ReqM & ((MemRWM == MEMRW_READ) | (MemRWM == MEMRW_WRITE));
  assign start     = (state == ST_IDLE) & rw_valid & ~FlushM;
  assign need1     = |ByteMaskSpillM[2*BB-1:BB];
  assign in_beat   = (state == ST_BEAT0) | (state == ST_BEAT1);
  // a flush arriving in the completing cycle is honoured just like a pending one
  assign flush_eff = flush_pend | FlushM;
  assign last_beat = (state == ST_BEAT1) | ~need1_q | flush_eff;

  // next-state selection
  always_comb begin
    state_next = state;
    case (state)
      ST_IDLE:  if (start) state_next = ST_BEAT0;
      ST_BEAT0: if (BusReady) begin
                  if (flush_eff)    state_next = ST_IDLE;
                  else if (need1_q) state_next = ST_BEAT1;
                  else              state_next = ST_DONE;
                end
      ST_BEAT1: if (BusReady) state_next = flush_eff ? ST_IDLE : ST_DONE;
      ST_DONE:  if (FlushM | ~StallM) state_next = ST_IDLE;
      default:  state_next = ST_IDLE;
    endcase
  end

  // state register and flush-pending flag
  always_ff @(posedge clk) begin
    if (reset) begin
      state      <= ST_IDLE;
      flush_pend <= 1'b0;
    end else begin
      state <= state_next;
      if (!in_beat || BusReady) flush_pend <= 1'b0;
      else if (FlushM)          flush_pend <= 1'b1;
    end
  end

  // request capture when leaving IDLE; the low offset bits are masked off here
  always_ff @(posedge clk) begin
    if (reset) begin
      rw_q    <= '0;
      base_q  <= '0;
      wdata_q <= '0;
      mask_q  <= '0;
      need1_q <= 1'b0;
    end else if (start) begin
      rw_q    <= MemRWM;
      base_q  <= IEUAdrM & ~XLEN'(BB - 1);
      wdata_q <= LSUWriteDataSpillM;
      mask_q  <= ByteMaskSpillM;
      need1_q <= need1;
    end
  end

  // read-data merge; beat 0 clears the high half so single-beat reads return zero there
  always_ff @(posedge clk) begin
    if (reset) begin
      rdata_q <= '0;
    end else if (BusReady && state == ST_BEAT0) begin
      rdata_q <= {{LLEN{1'b0}}, BusReadData};
    end else if (BusReady && state == ST_BEAT1) begin
      rdata_q[2*LLEN-1:LLEN] <= BusReadData;
    end
  end

  lsu_beat_mux #(.LLEN(LLEN)) u_beat_mux (
    .state      (state),
    .data_spill (wdata_q),
    .mask_spill (mask_q),
    .beat_data  (BusWriteData),
    .beat_mask  (BusByteMask)
  );

  assign BusAdr         = (state == ST_BEAT1) ? base_q + XLEN'(BB) : base_q;
  assign BusRead        = in_beat & (rw_q == MEMRW_READ);
  assign BusWrite       = in_beat & (rw_q == MEMRW_WRITE);
  assign ReadDataSpillM = rdata_q;

  // stall is released in the cycle the final beat completes, so the pipeline
  // advances on the same edge that lands the merged data
  assign SeqStallM = start | (in_beat & ~(BusReady & last_beat));

endmodule

// File: tb/tb_lsu_spill_bus_sequencer.sv
// Self-checking bench for lsu_spill_bus_sequencer: directed table, hand-written
// corner sequences and randomized transactions against a transaction-level model.
module tb_lsu_spill_bus_sequencer;
  import lsu_spill_bus_sequencer_pkg::*;

  logic          clk = 0;
  logic          reset, StallM, FlushM, ReqM;
  logic [1:0]    MemRWM;
  logic [63:0]   IEUAdrM;
  logic [127:0]  LSUWriteDataSpillM;
  logic [15:0]   ByteMaskSpillM;
  logic [63:0]   BusAdr;
  logic          BusRead, BusWrite;
  logic [7:0]    BusByteMask;
  logic [63:0]   BusWriteData;
  logic          BusReady;
  logic [63:0]   BusReadData;
  logic [127:0]  ReadDataSpillM;
  logic          SeqStallM;

  int n_cmp = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  lsu_spill_bus_sequencer dut (
    .clk(clk), .reset(reset), .StallM(StallM), .FlushM(FlushM), .ReqM(ReqM),
    .MemRWM(MemRWM), .IEUAdrM(IEUAdrM), .LSUWriteDataSpillM(LSUWriteDataSpillM),
    .ByteMaskSpillM(ByteMaskSpillM), .BusAdr(BusAdr), .BusRead(BusRead),
    .BusWrite(BusWrite), .BusByteMask(BusByteMask), .BusWriteData(BusWriteData),
    .BusReady(BusReady), .BusReadData(BusReadData), .ReadDataSpillM(ReadDataSpillM),
    .SeqStallM(SeqStallM)
  );

  typedef struct packed {
    logic [63:0]  adr;
    logic [1:0]   rw;
    logic [15:0]  mask;
    logic [127:0] wdata;
    logic [3:0]   w0;
    logic [3:0]   w1;
    logic [63:0]  rd0;
    logic [63:0]  rd1;
    logic [1:0]   e_nb;
    logic [63:0]  e_adr0;
    logic [63:0]  e_adr1;
    logic [7:0]   e_m0;
    logic [7:0]   e_m1;
    logic [63:0]  e_d0;
    logic [63:0]  e_d1;
    logic [7:0]   e_stall;
    logic [127:0] e_rd;
  } vec_t;

  vec_t tbl[4];

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // transaction-level reference: beats, addresses and stall length from the access rules
  function automatic vec_t model(input vec_t v);
    logic [63:0] base;
    base     = v.adr - (v.adr % 64'(LLENBYTES));
    v.e_nb   = (v.mask[15:8] != 8'h00) ? 2'd2 : 2'd1;
    v.e_adr0 = base;
    v.e_adr1 = base + 64'(LLENBYTES);
    v.e_m0   = v.mask[7:0];
    v.e_m1   = v.mask[15:8];
    v.e_d0   = v.wdata[63:0];
    v.e_d1   = v.wdata[127:64];
    v.e_stall = 8'(v.w0 + 1) + ((v.e_nb == 2) ? 8'(v.w1 + 1) : 8'd0);
    v.e_rd   = (v.e_nb == 2) ? {v.rd1, v.rd0} : {64'h0, v.rd0};
    return v;
  endfunction

  task automatic chk_zero(input string tag);
    chk({tag, " BusRead"}, BusRead, 0);
    chk({tag, " BusWrite"}, BusWrite, 0);
    chk({tag, " BusAdr"}, BusAdr, 0);
    chk({tag, " BusByteMask"}, BusByteMask, 0);
    chk({tag, " BusWriteData"}, BusWriteData, 0);
    chk({tag, " ReadDataSpillM"}, ReadDataSpillM, 0);
    chk({tag, " SeqStallM"}, SeqStallM, 0);
  endtask

  // drives one access from IDLE with a wait-state bus responder and checks it
  task automatic run_txn(input vec_t v, input string tag);
    int beat, wc, stall_cnt, bi;
    logic [63:0] s_adr[2];
    logic [7:0]  s_m[2];
    logic [63:0] s_d[2];
    logic acc, unstable, type_ok, timed_out, rdy;
    logic [3:0] wt;
    beat = 0; wc = 0; stall_cnt = 0; unstable = 0; type_ok = 1; timed_out = 1;
    s_adr[0] = 'x; s_adr[1] = 'x; s_m[0] = 'x; s_m[1] = 'x; s_d[0] = 'x; s_d[1] = 'x;
    @(negedge clk);
    ReqM = 1; MemRWM = v.rw; IEUAdrM = v.adr; LSUWriteDataSpillM = v.wdata;
    ByteMaskSpillM = v.mask; StallM = 0; FlushM = 0; BusReady = 0;
    #1;
    acc = SeqStallM & ~BusRead & ~BusWrite;
    if (SeqStallM) stall_cnt++;
    @(posedge clk); #1;
    IEUAdrM = {$urandom, $urandom};
    LSUWriteDataSpillM = {$urandom, $urandom, $urandom, $urandom};
    ByteMaskSpillM = 16'($urandom);
    MemRWM = 2'($urandom_range(0, 3));
    for (int cyc = 0; cyc < 100; cyc++) begin
      @(negedge clk);
      if (BusRead | BusWrite) begin
        bi = (beat > 1) ? 1 : beat;
        if (wc == 0) begin
          s_adr[bi] = BusAdr; s_m[bi] = BusByteMask; s_d[bi] = BusWriteData;
        end else if (BusAdr !== s_adr[bi] || BusByteMask !== s_m[bi] || BusWriteData !== s_d[bi]) begin
          unstable = 1;
        end
        if (BusRead !== (v.rw == MEMRW_READ) || BusWrite !== (v.rw == MEMRW_WRITE)) type_ok = 0;
        wt = (beat == 0) ? v.w0 : v.w1;
        rdy = (beat > 1) || (wc == int'(wt));
        BusReady = rdy;
        BusReadData = rdy ? ((beat == 0) ? v.rd0 : v.rd1) : {$urandom, $urandom};
        #1;
        if (SeqStallM) stall_cnt++;
        if (rdy) begin beat++; wc = 0; end
        else wc++;
      end else begin
        BusReady = 1'($urandom_range(0, 1));
        #1;
        if (SeqStallM) stall_cnt++;
        else begin timed_out = 0; break; end
      end
      @(posedge clk); #1;
      BusReady = 0;
    end
    ReqM = 0;
    BusReady = 0;
    chk({tag, " timeout"}, timed_out, 0);
    chk({tag, " accept"}, acc, 1);
    chk({tag, " beats"}, beat, v.e_nb);
    chk({tag, " adr0"}, s_adr[0], v.e_adr0);
    chk({tag, " mask0"}, s_m[0], v.e_m0);
    if (v.rw == MEMRW_WRITE) chk({tag, " wdata0"}, s_d[0], v.e_d0);
    if (v.e_nb == 2) begin
      chk({tag, " adr1"}, s_adr[1], v.e_adr1);
      chk({tag, " mask1"}, s_m[1], v.e_m1);
      if (v.rw == MEMRW_WRITE) chk({tag, " wdata1"}, s_d[1], v.e_d1);
    end
    chk({tag, " type"}, type_ok, 1);
    chk({tag, " stable"}, unstable, 0);
    chk({tag, " stall_cycles"}, stall_cnt, v.e_stall);
    if (v.rw == MEMRW_READ) chk({tag, " rdata"}, ReadDataSpillM, v.e_rd);
    @(posedge clk); #1;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    vec_t v;
    reset = 1; StallM = 0; FlushM = 0; ReqM = 0; MemRWM = 0; IEUAdrM = 0;
    LSUWriteDataSpillM = 0; ByteMaskSpillM = 0; BusReady = 0; BusReadData = 0;

    // directed table
    v = '0; v.rw = MEMRW_WRITE; v.adr = 64'h1006; v.mask = 16'h0300;
    v.wdata = {64'h0000_0000_0000_00AB, 64'hCD00_0000_0000_0000};
    v.e_nb = 2; v.e_adr0 = 64'h1000; v.e_adr1 = 64'h1008; v.e_m0 = 8'h00; v.e_m1 = 8'h03;
    v.e_d0 = 64'hCD00_0000_0000_0000; v.e_d1 = 64'hAB; v.e_stall = 2;
    tbl[0] = v;
    v = '0; v.rw = MEMRW_READ; v.adr = 64'h2000; v.mask = 16'h000F; v.w0 = 3;
    v.rd0 = 64'h1122334455667788; v.e_nb = 1; v.e_adr0 = 64'h2000; v.e_m0 = 8'h0F;
    v.e_stall = 4; v.e_rd = {64'h0, 64'h1122334455667788};
    tbl[1] = v;
    v = '0; v.rw = MEMRW_READ; v.adr = 64'h3004; v.mask = 16'h0FF0; v.w0 = 1; v.w1 = 2;
    v.rd0 = 64'hAAAA_AAAA_0000_1111; v.rd1 = 64'hBBBB_BBBB_2222_3333;
    v.e_nb = 2; v.e_adr0 = 64'h3000; v.e_adr1 = 64'h3008; v.e_m0 = 8'hF0; v.e_m1 = 8'h0F;
    v.e_stall = 5; v.e_rd = {64'hBBBB_BBBB_2222_3333, 64'hAAAA_AAAA_0000_1111};
    tbl[2] = v;
    v = '0; v.rw = MEMRW_WRITE; v.adr = 64'hFFFF_FFFF_FFFF_FFFC; v.mask = 16'hFFF0; v.w1 = 1;
    v.wdata = {64'h0123_4567_89AB_CDEF, 64'hFEDC_BA98_7654_3210};
    v.e_nb = 2; v.e_adr0 = 64'hFFFF_FFFF_FFFF_FFF8; v.e_adr1 = 64'h0; v.e_m0 = 8'hF0; v.e_m1 = 8'hFF;
    v.e_d0 = 64'hFEDC_BA98_7654_3210; v.e_d1 = 64'h0123_4567_89AB_CDEF; v.e_stall = 3;
    tbl[3] = v;

    repeat (3) @(posedge clk);
    #1 reset = 0;
    @(negedge clk);
    chk_zero("reset");

    for (int i = 0; i < 4; i++) run_txn(tbl[i], $sformatf("tbl%0d", i));

    // illegal access type and flush in IDLE are not accepted
    @(negedge clk);
    ReqM = 1; MemRWM = 2'b11; #1;
    chk("illegal_rw stall", SeqStallM, 0);
    @(posedge clk); #1;
    MemRWM = MEMRW_READ; FlushM = 1;
    @(negedge clk);
    chk("illegal_rw no_beat", BusRead | BusWrite, 0);
    chk("idle_flush stall", SeqStallM, 0);
    @(posedge clk); #1;
    FlushM = 0; ReqM = 0;
    @(negedge clk);
    chk("idle_flush no_beat", BusRead | BusWrite, 0);

    // flush during a BEAT0 wait of a two-beat read
    @(negedge clk);
    ReqM = 1; MemRWM = MEMRW_READ; IEUAdrM = 64'h4000; ByteMaskSpillM = 16'hFFFF;
    @(posedge clk); #1;
    @(negedge clk);
    chk("flush b0 read", BusRead, 1);
    FlushM = 1; ReqM = 0; #1;
    chk("flush b0 stall", SeqStallM, 1);
    @(posedge clk); #1 FlushM = 0;
    @(negedge clk);
    chk("flush held read", BusRead, 1);
    chk("flush held adr", BusAdr, 64'h4000);
    @(posedge clk); #1;
    @(negedge clk);
    BusReady = 1; BusReadData = 64'h5555_6666_7777_8888; #1;
    chk("flush complete stall", SeqStallM, 0);
    @(posedge clk); #1 BusReady = 0;
    @(negedge clk);
    chk("flush no beat1", BusRead | BusWrite, 0);
    chk("flush rdata", ReadDataSpillM, {64'h0, 64'h5555_6666_7777_8888});
    run_txn(model(tbl[2]), "after_flush");

    // reset while BEAT1 is waiting
    @(negedge clk);
    ReqM = 1; MemRWM = MEMRW_READ; IEUAdrM = 64'h5000; ByteMaskSpillM = 16'hFFFF;
    @(posedge clk); #1;
    @(negedge clk);
    BusReady = 1; BusReadData = 64'h9999;
    @(posedge clk); #1 BusReady = 0;
    @(negedge clk);
    chk("rst_b1 pre read", BusRead, 1);
    chk("rst_b1 pre adr", BusAdr, 64'h5008);
    reset = 1; ReqM = 0;
    @(posedge clk); #1 reset = 0;
    @(negedge clk);
    chk_zero("rst_b1");
    run_txn(tbl[1], "after_rst");

    // DONE holds under StallM, and a request there waits for IDLE
    @(negedge clk);
    ReqM = 1; MemRWM = MEMRW_READ; IEUAdrM = 64'h6000; ByteMaskSpillM = 16'h00FF; StallM = 0;
    @(posedge clk); #1;
    @(negedge clk);
    BusReady = 1; BusReadData = 64'h1234;
    @(posedge clk); #1 BusReady = 0; StallM = 1;
    @(negedge clk);
    chk("done_hold stall", SeqStallM, 0);
    @(posedge clk); #1;
    @(negedge clk);
    chk("done_hold stall2", SeqStallM, 0);
    chk("done_hold no_beat", BusRead | BusWrite, 0);
    StallM = 0; #1;
    chk("done_no_accept", SeqStallM, 0);
    @(posedge clk); #1;
    @(negedge clk);
    chk("idle_accept", SeqStallM, 1);
    @(posedge clk); #1;
    @(negedge clk);
    chk("idle_accept beat", BusRead, 1);
    BusReady = 1;
    @(posedge clk); #1 BusReady = 0; ReqM = 0;
    @(posedge clk); #1;

    // randomized traffic against the model
    for (int i = 0; i < 40; i++) begin
      v = '0;
      v.rw    = ($urandom_range(0, 1) == 1) ? MEMRW_READ : MEMRW_WRITE;
      v.adr   = {$urandom, $urandom};
      v.mask  = 16'($urandom);
      if ($urandom_range(0, 3) == 0) v.mask[15:8] = 8'h00;
      v.wdata = {$urandom, $urandom, $urandom, $urandom};
      v.w0    = 4'($urandom_range(0, 3));
      v.w1    = 4'($urandom_range(0, 3));
      v.rd0   = {$urandom, $urandom};
      v.rd1   = {$urandom, $urandom};
      run_txn(model(v), $sformatf("rnd%0d", i));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
